// File: rtl/fft_frame_packer_if.sv
// ---------------------------------------------------------------------------
// fft_frame_packer_if
//   Bundles the two streams that cross the fft_frame_packer boundary:
//   the serial sample stream on the way in and the packed frame on the
//   way out.
//
//   Signals
//     s_data      [DW-1:0]        input sample
//     s_valid                     s_data is valid
//     s_last                      last sample of a frame (accepted beats only)
//     s_ready                     packer can take a sample this cycle
//     frame_data  [WORDS*DW-1:0]  packed frame, slot k at [DW*k +: DW]
//     frame_valid                 frame_data holds a complete frame
//     frame_ready                 downstream consumes the frame this cycle
//     err_short                   one-cycle pulse on an early (s_last) close
//
//   Modports
//     master : the environment (sample producer + frame consumer)
//     slave  : the packer itself
// ---------------------------------------------------------------------------
interface fft_frame_packer_if #(
  parameter int WORDS = 64,
  parameter int DW    = 32
);

  logic [DW-1:0]       s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [WORDS*DW-1:0] frame_data;
  logic                frame_valid;
  logic                frame_ready;
  logic                err_short;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output frame_ready,
    input  s_ready,
    input  frame_data,
    input  frame_valid,
    input  err_short
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  frame_ready,
    output s_ready,
    output frame_data,
    output frame_valid,
    output err_short
  );

endinterface

// File: rtl/fft_frame_packer.sv
// ---------------------------------------------------------------------------
// fft_frame_packer
//   Input stage of the 64-word FFT datapath. Collects a serial stream of
//   DW-bit samples and packs each group of WORDS samples into one parallel
//   frame for the butterfly pipeline. Two frame buffers (A = 0, B = 1) are
//   used ping-pong: one fills while the other is held stable downstream.
//
//   Ports
//     clk    : single clock, rising edge
//     reset  : asynchronous, active-low reset
//     bus    : fft_frame_packer_if.slave (sample stream in, frame out)
//
//   Build option
//     FFT_BITREV_EN : when defined, the beat with word index k lands in slot
//                     bitrev(k) so the frame leaves in bit-reversed order for
//                     decimation-in-time. Undefined: natural order.
//
//   Each buffer runs a small EMPTY -> FILL -> FULL -> EMPTY life cycle.
//   wr_sel names the buffer being filled, rd_sel the buffer presented.
//   s_ready and frame_valid depend only on registered buffer states, so
//   there is no combinational path from frame_ready to s_ready.
// ---------------------------------------------------------------------------
module fft_frame_packer #(
  parameter int WORDS = 64,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  fft_frame_packer_if.slave   bus
);

  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_FILL  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // buffer life-cycle state and pointers
  buf_state_e          state_q [2];
  buf_state_e          state_d [2];
  logic                wr_sel;
  logic                wr_sel_d;
  logic                rd_sel;
  logic                rd_sel_d;
  logic [IW-1:0]       widx;
  logic [IW-1:0]       widx_d;

  // frame storage
  logic [DW-1:0]       buf_q [2][WORDS];
  logic [WORDS*DW-1:0] frame_data_w;

  // handshake decode
  logic                s_ready_w;
  logic                frame_valid_w;
  logic                accept;
  logic                last_slot;
  logic                close;
  logic                early;
  logic                consume;
  logic [IW-1:0]       slot;
  logic                err_short_p1;

`ifdef FFT_BITREV_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] k);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) begin
      r[i] = k[IW-1-i];
    end
    return r;
  endfunction

  assign slot = bitrev(widx);
`else
  assign slot = widx;
`endif

  // -------------------------------------------------------------------------
  // Output / decode logic (registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    s_ready_w     = (state_q[wr_sel] != BUF_FULL);
    frame_valid_w = (state_q[rd_sel] == BUF_FULL);
    last_slot     = (widx == IW'(WORDS - 1));
    accept        = bus.s_valid && s_ready_w;
    close         = accept && (last_slot || bus.s_last);
    // an s_last at the final slot is a normal close, not a short frame
    early         = accept && bus.s_last && !last_slot;
    consume       = frame_valid_w && bus.frame_ready;
  end

  assign bus.s_ready     = s_ready_w;
  assign bus.frame_valid = frame_valid_w;
  assign bus.frame_data  = frame_data_w;
  assign bus.err_short   = err_short_p1;

  // frame_data is a pure mux of the presented buffer's registers
  always_comb begin
    frame_data_w = '0;
    for (int k = 0; k < WORDS; k++) begin
      frame_data_w[k*DW +: DW] = buf_q[rd_sel][k];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  //   The closing and consuming buffers never coincide: a close needs the
  //   write buffer to be non-FULL, a consume needs the read buffer FULL,
  //   so both updates can be applied in the same cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_sel_d   = wr_sel;
    rd_sel_d   = rd_sel;
    widx_d     = widx;

    if (accept) begin
      if (close) begin
        state_d[wr_sel] = BUF_FULL;
        wr_sel_d        = ~wr_sel;
        widx_d          = '0;
      end else begin
        state_d[wr_sel] = BUF_FILL;
        widx_d          = widx + IW'(1);
      end
    end

    if (consume) begin
      state_d[rd_sel] = BUF_EMPTY;
      rd_sel_d        = ~rd_sel;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0]   <= BUF_EMPTY;
      state_q[1]   <= BUF_EMPTY;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      widx         <= '0;
      err_short_p1 <= 1'b0;
    end else begin
      state_q[0]   <= state_d[0];
      state_q[1]   <= state_d[1];
      wr_sel       <= wr_sel_d;
      rd_sel       <= rd_sel_d;
      widx         <= widx_d;
      err_short_p1 <= early;
    end
  end

  // -------------------------------------------------------------------------
  // Frame storage
  //   The first beat of a frame wipes the whole buffer so that slots an
  //   early close never reaches read back as zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < WORDS; k++) begin
          buf_q[b][k] <= '0;
        end
      end
    end else if (accept) begin
      if (widx == '0) begin
        for (int k = 0; k < WORDS; k++) begin
          buf_q[wr_sel][k] <= '0;
        end
      end
      buf_q[wr_sel][slot] <= bus.s_data;
    end
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_packer
//   Directed and randomized stimulus for fft_frame_packer. A reference model
//   keeps a queue of completed frames awaiting delivery plus the frame being
//   assembled; outputs are compared against it after every clock edge.
// ---------------------------------------------------------------------------
module tb_fft_frame_packer;

  localparam int WORDS = 64;
  localparam int DW    = 32;
  localparam int FW    = WORDS * DW;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fft_frame_packer_if #(.WORDS(WORDS), .DW(DW)) bus ();

  fft_frame_packer #(.WORDS(WORDS), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  logic [FW-1:0] exp_q [$];
  logic [DW-1:0] cur [WORDS];
  int            widx_m   = 0;
  bit            err_m    = 1'b0;
  int            cyc      = 0;
  int            hs_cyc [$];
  bit            rand_rdy = 1'b0;

  function automatic int bitrev6(input int k);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  function automatic int slot_of(input int k);
`ifdef FFT_BITREV_EN
    return bitrev6(k);
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] exp_f);
    int bad;
    n_vec++;
    assert (bus.frame_data === exp_f) else begin
      n_miss++;
      bad = 0;
      for (int k = WORDS - 1; k >= 0; k--)
        if (bus.frame_data[k*DW +: DW] !== exp_f[k*DW +: DW]) bad = k;
      $error("FAIL %s slot %0d: observed %08h expected %08h", tag, bad,
             bus.frame_data[bad*DW +: DW], exp_f[bad*DW +: DW]);
    end
  endtask

  task automatic check_outputs();
    chk1("s_ready", bus.s_ready, exp_q.size() < 2);
    chk1("frame_valid", bus.frame_valid, exp_q.size() > 0);
    chk1("err_short", bus.err_short, err_m);
    if (exp_q.size() > 0) chk_frame("frame_data", exp_q[0]);
  endtask

  // one clock: predict the handshakes from pre-edge state, advance the model
  task automatic cycle();
    bit            acc;
    bit            cons;
    logic [FW-1:0] f;
    if (rand_rdy) bus.frame_ready = 1'($urandom_range(0, 1));
    acc  = bus.s_valid && (exp_q.size() < 2);
    cons = (exp_q.size() > 0) && bus.frame_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (cons) begin
      void'(exp_q.pop_front());
      hs_cyc.push_back(cyc);
    end
    err_m = 1'b0;
    if (acc) begin
      if (widx_m == 0) for (int k = 0; k < WORDS; k++) cur[k] = '0;
      cur[slot_of(widx_m)] = bus.s_data;
      if (widx_m == WORDS - 1 || bus.s_last) begin
        for (int k = 0; k < WORDS; k++) f[k*DW +: DW] = cur[k];
        exp_q.push_back(f);
        err_m  = (widx_m != WORDS - 1);
        widx_m = 0;
      end else begin
        widx_m++;
      end
    end
    check_outputs();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    bit a;
    bit got;
    got         = 1'b0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      a = (exp_q.size() < 2);
      cycle();
      got = a;
    end
    n_vec++;
    assert (got) else begin
      n_miss++;
      $error("FAIL send_beat: observed no acceptance expected acceptance within 300 cycles");
    end
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    bus.s_valid     = 1'b0;
    bus.s_last      = 1'b0;
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    cycle();
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    reset       = 1'b0;
    #2;
    exp_q.delete();
    widx_m = 0;
    err_m  = 1'b0;
    for (int k = 0; k < WORDS; k++) cur[k] = '0;
    check_outputs();
    chk_frame("reset frame_data", '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    reset           = 1'b0;
    bus.s_data      = '0;
    bus.s_valid     = 1'b0;
    bus.s_last      = 1'b0;
    bus.frame_ready = 1'b0;
    #1;
    do_reset();
    idle(2);

    // natural fill, values k+1
    bus.frame_ready = 1'b1;
    for (int k = 0; k < WORDS; k++) send_beat(DW'(k + 1), 1'b0);
    chk1("fill valid", bus.frame_valid, 1'b1);
    chk("fill slot0", bus.frame_data[31:0], 32'h0000_0001);
    chk("fill slot63", bus.frame_data[FW-1 -: DW], 32'h0000_0040);
    idle(2);

    // early close, 10 beats
    for (int k = 0; k < 10; k++) send_beat(32'hA5A5_A5A5, k == 9);
    chk1("early err", bus.err_short, 1'b1);
    chk("early slot9", bus.frame_data[slot_of(9)*DW +: DW], 32'hA5A5_A5A5);
    chk("early slot10", bus.frame_data[slot_of(10)*DW +: DW], 32'h0);
    idle(2);
    // second short frame lands in the buffer that held the full frame
    for (int k = 0; k < 3; k++) send_beat($urandom, k == 2);
    idle(2);

    // back-pressure: 130 beats with the consumer stalled
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 128; k++) send_beat($urandom, 1'b0);
    chk1("bp s_ready low", bus.s_ready, 1'b0);
    bus.s_data  = $urandom;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b0;
    repeat (5) cycle();
    bus.frame_ready = 1'b1;
    cycle();
    bus.frame_ready = 1'b0;
    chk1("bp s_ready back", bus.s_ready, 1'b1);
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b1);
    drain();

    // full-rate streaming, 4 frames
    hs_cyc.delete();
    bus.frame_ready = 1'b1;
    c0 = cyc;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < WORDS; k++) send_beat($urandom, 1'b0);
    chk("stream cycles", DW'(cyc - c0), DW'(4 * WORDS));
    idle(2);
    chk("stream handshakes", DW'(hs_cyc.size()), 32'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("stream spacing", DW'(hs_cyc[i] - hs_cyc[i-1]), DW'(WORDS));

    // value-k frame: slot placement
    for (int k = 0; k < WORDS; k++) send_beat(DW'(k), 1'b0);
`ifdef FFT_BITREV_EN
    chk("order slot1", bus.frame_data[1*DW +: DW], 32'd32);
    chk("order slot32", bus.frame_data[32*DW +: DW], 32'd1);
`else
    chk("order slot1", bus.frame_data[1*DW +: DW], 32'd1);
    chk("order slot32", bus.frame_data[32*DW +: DW], 32'd32);
`endif
    chk("order slot63", bus.frame_data[63*DW +: DW], 32'd63);
    chk("order slot0", bus.frame_data[0 +: DW], 32'd0);
    idle(2);

    // randomized traffic
    rand_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_beat($urandom, $urandom_range(0, 24) == 0);
    end
    rand_rdy = 1'b0;
    drain();

    // reset mid-stream with one full and one partial frame held
    bus.frame_ready = 1'b0;
    for (int k = 0; k < 70; k++) send_beat($urandom, 1'b0);
    do_reset();
    idle(1);
    bus.frame_ready = 1'b1;
    for (int k = 0; k < WORDS; k++) send_beat(DW'(k + 1), 1'b0);
    chk("post-reset slot0", bus.frame_data[0 +: DW], 32'h0000_0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
